// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
// Owns the column/row counters, shapes HSync/VSync from the porch and sync widths,
// blanks video outside the active area and delays everything by PIPE_DELAY stages
// so syncs, video, o_Active and o_Frame_Start leave the block mutually aligned.
// Optional feature: define VGA_BORDER_EN to paint an all-ones one-pixel border
// around the active area (inputs ignored on those pixels).
module vga_timing_gen #(
  parameter int VIDEO_WIDTH   = 3,
  parameter int COUNT_WIDTH   = 10,
  parameter int ACTIVE_COLS   = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int ACTIVE_ROWS   = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter bit SYNC_POL      = 1'b0,
  parameter int PIPE_DELAY    = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic [COUNT_WIDTH-1:0] o_Col_Count,
  output logic [COUNT_WIDTH-1:0] o_Row_Count,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Active,
  output logic                   o_Frame_Start
);

  localparam int H_TOTAL      = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL      = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int H_SYNC_START = ACTIVE_COLS + H_FRONT_PORCH;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_WIDTH;
  localparam int V_SYNC_START = ACTIVE_ROWS + V_FRONT_PORCH;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_WIDTH;

  // Region bounds are compared one bit wider than the counters so an end bound
  // equal to 2**COUNT_WIDTH still fits.
  localparam logic [COUNT_WIDTH:0] H_ACT_X = (COUNT_WIDTH+1)'(ACTIVE_COLS);
  localparam logic [COUNT_WIDTH:0] H_SS_X  = (COUNT_WIDTH+1)'(H_SYNC_START);
  localparam logic [COUNT_WIDTH:0] H_SE_X  = (COUNT_WIDTH+1)'(H_SYNC_END);
  localparam logic [COUNT_WIDTH:0] V_ACT_X = (COUNT_WIDTH+1)'(ACTIVE_ROWS);
  localparam logic [COUNT_WIDTH:0] V_SS_X  = (COUNT_WIDTH+1)'(V_SYNC_START);
  localparam logic [COUNT_WIDTH:0] V_SE_X  = (COUNT_WIDTH+1)'(V_SYNC_END);

  localparam logic [COUNT_WIDTH-1:0] H_LAST = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST = COUNT_WIDTH'(V_TOTAL - 1);

`ifdef VGA_BORDER_EN
  localparam logic [COUNT_WIDTH-1:0] H_ACT_LAST = COUNT_WIDTH'(ACTIVE_COLS - 1);
  localparam logic [COUNT_WIDTH-1:0] V_ACT_LAST = COUNT_WIDTH'(ACTIVE_ROWS - 1);
`endif

  if (H_TOTAL > 2**COUNT_WIDTH) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL %0d does not fit COUNT_WIDTH %0d", H_TOTAL, COUNT_WIDTH);
  end
  if (V_TOTAL > 2**COUNT_WIDTH) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL %0d does not fit COUNT_WIDTH %0d", V_TOTAL, COUNT_WIDTH);
  end
  if (PIPE_DELAY < 1) begin : g_pipe_chk
    $error("vga_timing_gen: PIPE_DELAY must be at least 1");
  end

  logic [COUNT_WIDTH-1:0] col;
  logic [COUNT_WIDTH-1:0] row;

  // Raster position: column runs every cycle, row steps on column wrap.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col <= '0;
      row <= '0;
    end else if (col == H_LAST) begin
      col <= '0;
      if (row == V_LAST) row <= '0;
      else               row <= row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  assign o_Col_Count = col;
  assign o_Row_Count = row;

  logic [COUNT_WIDTH:0]   col_x;
  logic [COUNT_WIDTH:0]   row_x;
  logic                   active_c;
  logic                   hs_c;
  logic                   vs_c;
  logic                   fs_c;
  logic [VIDEO_WIDTH-1:0] red_c;
  logic [VIDEO_WIDTH-1:0] grn_c;
  logic [VIDEO_WIDTH-1:0] blu_c;

  assign col_x = {1'b0, col};
  assign row_x = {1'b0, row};

  // Decode the current raster position into syncs, active flag and blanked video.
  always_comb begin
    active_c = (col_x < H_ACT_X) && (row_x < V_ACT_X);
    hs_c     = ((col_x >= H_SS_X) && (col_x < H_SE_X)) ? SYNC_POL : ~SYNC_POL;
    vs_c     = ((row_x >= V_SS_X) && (row_x < V_SE_X)) ? SYNC_POL : ~SYNC_POL;
    fs_c     = (col == '0) && (row == '0);
    red_c    = '0;
    grn_c    = '0;
    blu_c    = '0;
    if (active_c) begin
`ifdef VGA_BORDER_EN
      if ((col == '0) || (col == H_ACT_LAST) || (row == '0) || (row == V_ACT_LAST)) begin
        red_c = '1;
        grn_c = '1;
        blu_c = '1;
      end else begin
        red_c = i_Red_Video;
        grn_c = i_Grn_Video;
        blu_c = i_Blu_Video;
      end
`else
      red_c = i_Red_Video;
      grn_c = i_Grn_Video;
      blu_c = i_Blu_Video;
`endif
    end
  end

  logic                   hs_q     [PIPE_DELAY];
  logic                   vs_q     [PIPE_DELAY];
  logic                   active_q [PIPE_DELAY];
  logic                   fs_q     [PIPE_DELAY];
  logic [VIDEO_WIDTH-1:0] red_q    [PIPE_DELAY];
  logic [VIDEO_WIDTH-1:0] grn_q    [PIPE_DELAY];
  logic [VIDEO_WIDTH-1:0] blu_q    [PIPE_DELAY];

  // Output delay line; reset flushes every stage so nothing stale leaks out after release.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        hs_q[i]     <= ~SYNC_POL;
        vs_q[i]     <= ~SYNC_POL;
        active_q[i] <= 1'b0;
        fs_q[i]     <= 1'b0;
        red_q[i]    <= '0;
        grn_q[i]    <= '0;
        blu_q[i]    <= '0;
      end
    end else begin
      hs_q[0]     <= hs_c;
      vs_q[0]     <= vs_c;
      active_q[0] <= active_c;
      fs_q[0]     <= fs_c;
      red_q[0]    <= red_c;
      grn_q[0]    <= grn_c;
      blu_q[0]    <= blu_c;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_q[i]     <= hs_q[i-1];
        vs_q[i]     <= vs_q[i-1];
        active_q[i] <= active_q[i-1];
        fs_q[i]     <= fs_q[i-1];
        red_q[i]    <= red_q[i-1];
        grn_q[i]    <= grn_q[i-1];
        blu_q[i]    <= blu_q[i-1];
      end
    end
  end

  assign o_HSync       = hs_q[PIPE_DELAY-1];
  assign o_VSync       = vs_q[PIPE_DELAY-1];
  assign o_Active      = active_q[PIPE_DELAY-1];
  assign o_Frame_Start = fs_q[PIPE_DELAY-1];
  assign o_Red_Video   = red_q[PIPE_DELAY-1];
  assign o_Grn_Video   = grn_q[PIPE_DELAY-1];
  assign o_Blu_Video   = blu_q[PIPE_DELAY-1];

endmodule
